// File: rtl/hilo_md_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// states and the start-class decode also used by the hazard unit.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // High for the ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_md_start(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // High for the two divide ops (they use DIV_LAT instead of MUL_LAT).
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_md_unit_if.sv
// E-stage request/response bundle between the pipeline and the HI/LO unit.
interface hilo_md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, hi, lo
    );
endinterface

// File: rtl/hilo_md_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed on the start
// edge and held pending; it is committed after MUL_LAT or DIV_LAT cycles.
module hilo_md_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    hilo_md_unit_if.slave    bus
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    state_t           state;
    logic [CW-1:0]    counter;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    // Combinational result datapath
    logic [W2-1:0]    a_sext;
    logic [W2-1:0]    b_sext;
    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic [W2-1:0]    acc;
    logic             sgn_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_u;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;
    logic [W2-1:0]    res;

    // Product, accumulate and sign-magnitude divide for the requested op.
    // Signed divide works on magnitudes; most-negative / -1 falls out as
    // quotient = most-negative, remainder = 0 through wrap-around negation.
    always_comb begin
        a_sext   = {{WIDTH{bus.rs_val[WIDTH-1]}}, bus.rs_val};
        b_sext   = {{WIDTH{bus.rt_val[WIDTH-1]}}, bus.rt_val};
        prod_s   = a_sext * b_sext;
        prod_u   = {{WIDTH{1'b0}}, bus.rs_val} * {{WIDTH{1'b0}}, bus.rt_val};
        acc      = {hi_q, lo_q};

        sgn_div  = (bus.op == OP_DIV);
        a_neg    = sgn_div & bus.rs_val[WIDTH-1];
        b_neg    = sgn_div & bus.rt_val[WIDTH-1];
        a_abs    = a_neg ? -bus.rs_val : bus.rs_val;
        b_abs    = b_neg ? -bus.rt_val : bus.rt_val;
        div_zero = (bus.rt_val == '0);
        // Divisor forced to 1 on zero so the divider never sees x/0;
        // the result is discarded in that case anyway.
        divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_abs;
        q_u      = a_abs / divisor;
        r_u      = a_abs % divisor;
        quot     = (a_neg ^ b_neg) ? -q_u : q_u;
        rem      = a_neg ? -r_u : r_u;

        case (bus.op)
            OP_MULT:          res = prod_s;
            OP_MULTU:         res = prod_u;
            OP_MADD:          res = acc + prod_s;
            OP_MADDU:         res = acc + prod_u;
            OP_MSUB:          res = acc - prod_s;
            OP_MSUBU:         res = acc - prod_u;
            OP_DIV, OP_DIVU:  res = {rem, quot};
            default:          res = acc;
        endcase
    end

    // IDLE/BUSY control with HI/LO, busy and pending-result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && is_md_start(bus.op)) begin
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                        counter <= is_div_op(bus.op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                        pend_hi <= res[W2-1:WIDTH];
                        pend_lo <= res[WIDTH-1:0];
                        pend_wr <= !(is_div_op(bus.op) && div_zero);
                    end else if (bus.op == OP_MTHI) begin
                        hi_q <= bus.rs_val;
                    end else if (bus.op == OP_MTLO) begin
                        lo_q <= bus.rs_val;
                    end
                end
                BUSY: begin
                    if (counter == CW'(1)) begin
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        counter <= '0;
                        pend_wr <= 1'b0;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
